uart_tx_arbiter: RTL

- Shares one UART transmitter (clk/rst, transmit pulse, tx_byte, is_transmitting handshake) between N byte-stream requesters, e.g. console, commit-trace dump and debug monitor.
- Round-robin arbitration at packet granularity: a granted requester keeps the UART until it presents a byte flagged last.
- Optional channel-tag header byte per packet; idle watchdog revokes a stalled grant.
- Sits between the SoC byte sources and the uart instance on the Nexys4 DDR top and its bench.

---
 rtl/uart_arb_pkg.sv | 33 +++
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    TXW
  } arb_state_t;

  // Upper nibble of the per-packet channel-tag header byte.
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  // First set bit of req at or after ptr, wrapping at n (not at 8). Returns ptr if none is set.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART transmit handshake shared by the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               uart_transmit;
  logic [7:0]         uart_tx_byte;
  logic               uart_is_transmitting;

  // master: byte sources and the UART; slave: the arbiter.
  modport master (
    output req_valid, req_data, req_last, uart_is_transmitting,
    input  req_ready, uart_transmit, uart_tx_byte
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte
  );
endinterface

// File: rtl/rr_picker.sv
// Registered round-robin priority encoder: holds the rr pointer and the latched grant.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             pick_i,
  input  logic             adv_i,
  output logic [2:0]       grant_id_o
);

  logic [2:0] ptr_q;
  logic [2:0] grant_q;

  // Latch a new grant on pick; move the pointer past the current grant on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= 3'd0;
      grant_q <= 3'd0;
    end else begin
      if (pick_i) grant_q <= rr_pick(8'(req_i), ptr_q, N_REQ);
      if (adv_i)  ptr_q   <= (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
    end
  end

  assign grant_id_o = grant_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte streams, round-robin per packet,
// with an optional channel-tag header byte and an idle watchdog on stalled grants.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TAG_EN   = 1,
  parameter int unsigned IDLE_MAX = 1024
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic [2:0]       grant_id,
  output logic             busy,
  output logic             abort_pulse,
  output logic [2:0]       abort_id
);

  localparam int unsigned CntW = $clog2(IDLE_MAX + 1);

  arb_state_t      state_q;
  logic [7:0]      tx_byte_q;
  logic            transmit_q;
  logic            last_q;
  logic            hdr_done_q;
  logic            guard_q;
  logic            abort_pulse_q;
  logic [2:0]      abort_id_q;
  logic [CntW-1:0] idle_cnt_q;

  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [N_REQ-1:0] ready_w;
  logic             xfer;
  logic             abort_now;
  logic             txw_done;
  logic             pick_en;
  logic             adv_en;

  // Route the granted requester's stream; ready only to the grant, only in DATA with UART free.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    ready_w   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_valid  = bus.req_valid[i];
        sel_last   = bus.req_last[i];
        sel_data   = bus.req_data[8*i +: 8];
        ready_w[i] = (state_q == DATA) && !bus.uart_is_transmitting;
      end
    end
  end

  assign xfer      = (state_q == DATA) && !bus.uart_is_transmitting && sel_valid;
  assign abort_now = (state_q == DATA) && !sel_valid && (idle_cnt_q == CntW'(IDLE_MAX - 1));
  assign txw_done  = (state_q == TXW) && !guard_q && !bus.uart_is_transmitting;
  // A frame left running by a reset must finish before anyone is granted.
  assign pick_en   = (state_q == IDLE) && (|bus.req_valid) && !bus.uart_is_transmitting;
  assign adv_en    = (txw_done && last_q && !hdr_done_q) || abort_now;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .clk        (clk),
    .rst        (rst),
    .req_i      (bus.req_valid),
    .pick_i     (pick_en),
    .adv_i      (adv_en),
    .grant_id_o (grant_id)
  );

  // Packet FSM with registered UART strobe/byte, watchdog counter and abort report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_byte_q     <= 8'h00;
      transmit_q    <= 1'b0;
      last_q        <= 1'b0;
      hdr_done_q    <= 1'b0;
      guard_q       <= 1'b0;
      abort_pulse_q <= 1'b0;
      abort_id_q    <= 3'd0;
      idle_cnt_q    <= '0;
    end else begin
      transmit_q    <= 1'b0;
      abort_pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          idle_cnt_q <= '0;
          hdr_done_q <= 1'b0;
          if (pick_en) state_q <= (TAG_EN != 0) ? HDR : DATA;
        end
        HDR: begin
          tx_byte_q  <= {HDR_MAGIC, 1'b0, grant_id};
          transmit_q <= 1'b1;
          hdr_done_q <= 1'b1;
          guard_q    <= 1'b1;
          state_q    <= TXW;
        end
        DATA: begin
          if (xfer) begin
            tx_byte_q  <= sel_data;
            last_q     <= sel_last;
            hdr_done_q <= 1'b0;
            transmit_q <= 1'b1;
            guard_q    <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= TXW;
          end else if (abort_now) begin
            abort_pulse_q <= 1'b1;
            abort_id_q    <= grant_id;
            idle_cnt_q    <= '0;
            state_q       <= IDLE;
          end else if (!sel_valid && (idle_cnt_q != '1)) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        TXW: begin
          // The UART only raises is_transmitting after seeing the strobe, so skip one cycle.
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (txw_done) begin
            state_q <= (last_q && !hdr_done_q) ? IDLE : DATA;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready_w;
  assign bus.uart_transmit = transmit_q;
  assign bus.uart_tx_byte  = tx_byte_q;
  assign busy              = (state_q != IDLE);
  assign abort_pulse       = abort_pulse_q;
  assign abort_id          = abort_id_q;

endmodule
